// File: rtl/mat_mult_job_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mat_mult_pkg : shared types and sizing for the matmul job arbiter   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mat_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Packed complex matrix: N*N elements, each a 64-bit real and 64-bit imaginary word.
  function automatic int mat_width(input int n);
    return 2 * 64 * n * n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_mult_job_arbiter_rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2 : two-input round-robin grant, favours the non-last one |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_arbiter2
  import mat_mult_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_id_o,
  output logic       grant_valid_o
);

  assign grant_valid_o = |req_i;
  assign grant_id_o    = req_i[1] & (~req_i[0] | ~last_grant_i);

endmodule
`default_nettype wire

// File: rtl/mat_mult_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mat_mult_job_arbiter : shares one matmul engine between two clients |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mat_mult_job_arbiter
  import mat_mult_pkg::*;
#(
  parameter  int mat_num_row    = 4,
  parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int MW             = mat_width(mat_num_row)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req_valid,
  output logic          r0_req_ready,
  input  logic [MW-1:0] r0_mat_a,
  input  logic [MW-1:0] r0_mat_b,
  output logic          r0_resp_valid,
  input  logic          r0_resp_ready,
  input  logic          r1_req_valid,
  output logic          r1_req_ready,
  input  logic [MW-1:0] r1_mat_a,
  input  logic [MW-1:0] r1_mat_b,
  output logic          r1_resp_valid,
  input  logic          r1_resp_ready,
  output logic [MW-1:0] resp_mat,
  output logic          resp_err,
  output logic          eng_start,
  output logic          eng_valid,
  output logic [MW-1:0] eng_mat_a,
  output logic [MW-1:0] eng_mat_b,
  input  logic [MW-1:0] eng_mat_out,
  input  logic          eng_done,
  output logic          busy,
  output logic [15:0]   job_count,
  output logic [7:0]    timeout_count
);

  localparam int             WDW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_id_q, grant_id_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [MW-1:0]  mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic [MW-1:0]  resp_mat_q, resp_mat_d;
  logic           resp_err_q, resp_err_d;
  logic [15:0]    job_count_q, job_count_d;
  logic [7:0]     timeout_count_q, timeout_count_d;

  logic arb_id, arb_valid, accept, resp_ready_sel;

  rr_arbiter2 u_arb (
    .req_i         ({r1_req_valid, r0_req_valid}),
    .last_grant_i  (last_grant_q),
    .grant_id_o    (arb_id),
    .grant_valid_o (arb_valid)
  );

  assign accept         = (state_q == IDLE) && arb_valid;
  assign resp_ready_sel = grant_id_q ? r1_resp_ready : r0_resp_ready;

  assign r0_req_ready  = accept && !arb_id;
  assign r1_req_ready  = accept && arb_id;
  assign r0_resp_valid = (state_q == RESP) && !grant_id_q;
  assign r1_resp_valid = (state_q == RESP) && grant_id_q;
  assign eng_start     = (state_q == RUN);
  assign eng_valid     = (state_q == RUN);
  assign eng_mat_a     = mat_a_q;
  assign eng_mat_b     = mat_b_q;
  assign resp_mat      = resp_mat_q;
  assign resp_err      = resp_err_q;
  assign busy          = (state_q != IDLE);
  assign job_count     = job_count_q;
  assign timeout_count = timeout_count_q;

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_id_d      = grant_id_q;
    wd_d            = wd_q;
    mat_a_d         = mat_a_q;
    mat_b_d         = mat_b_q;
    resp_mat_d      = resp_mat_q;
    resp_err_d      = resp_err_q;
    job_count_d     = job_count_q;
    timeout_count_d = timeout_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mat_a_d    = arb_id ? r1_mat_a : r0_mat_a;
          mat_b_d    = arb_id ? r1_mat_b : r0_mat_b;
          grant_id_d = arb_id;
          wd_d       = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        wd_d = wd_q + WDW'(1);
        // A completion on the expiry cycle still counts as a good job.
        if (eng_done) begin
          resp_mat_d  = eng_mat_out;
          resp_err_d  = 1'b0;
          job_count_d = job_count_q + 16'd1;
          state_d     = RESP;
        end else if (wd_q == WD_LAST) begin
          resp_mat_d = '0;
          resp_err_d = 1'b1;
          if (timeout_count_q != 8'hFF) begin
            timeout_count_d = timeout_count_q + 8'd1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_sel) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      grant_id_q      <= 1'b0;
      wd_q            <= '0;
      mat_a_q         <= '0;
      mat_b_q         <= '0;
      resp_mat_q      <= '0;
      resp_err_q      <= 1'b0;
      job_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_id_q      <= grant_id_d;
      wd_q            <= wd_d;
      mat_a_q         <= mat_a_d;
      mat_b_q         <= mat_b_d;
      resp_mat_q      <= resp_mat_d;
      resp_err_q      <= resp_err_d;
      job_count_q     <= job_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mat_mult_job_arbiter : directed bench with a complex matmul model|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mat_mult_job_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;
  localparam int MW = 2 * 64 * N * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req_valid, r0_req_ready, r0_resp_valid, r0_resp_ready;
  logic          r1_req_valid, r1_req_ready, r1_resp_valid, r1_resp_ready;
  logic [MW-1:0] r0_mat_a, r0_mat_b, r1_mat_a, r1_mat_b;
  logic [MW-1:0] resp_mat, eng_mat_a, eng_mat_b, eng_mat_out;
  logic          resp_err, eng_start, eng_valid, eng_done, busy;
  logic [15:0]   job_count;
  logic [7:0]    timeout_count;

  int errors = 0;
  int checks = 0;
  int eng_delay = 1000;
  int eng_cnt = 0;
  logic [MW-1:0] IDENT, A0, A1, B0, B1, exp_m;

  mat_mult_job_arbiter #(.mat_num_row(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_mat_a(r0_mat_a), .r0_mat_b(r0_mat_b),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_mat_a(r1_mat_a), .r1_mat_b(r1_mat_b),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .resp_mat(resp_mat), .resp_err(resp_err),
    .eng_start(eng_start), .eng_valid(eng_valid),
    .eng_mat_a(eng_mat_a), .eng_mat_b(eng_mat_b),
    .eng_mat_out(eng_mat_out), .eng_done(eng_done),
    .busy(busy), .job_count(job_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // Element (i,j) sits at bits [128*(i*N+j) +: 128]; low word real, high word imaginary.
  function automatic logic [MW-1:0] cmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] r;
    logic [63:0]   ar, ai, br, bi, sr, si;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        sr = '0;
        si = '0;
        for (int k = 0; k < N; k++) begin
          ar = a[128*(i*N+k) +: 64];
          ai = a[128*(i*N+k)+64 +: 64];
          br = b[128*(k*N+j) +: 64];
          bi = b[128*(k*N+j)+64 +: 64];
          sr = sr + ar * br - ai * bi;
          si = si + ar * bi + ai * br;
        end
        r[128*(i*N+j) +: 64]    = sr;
        r[128*(i*N+j)+64 +: 64] = si;
      end
    end
    return r;
  endfunction

  // Engine model: done in the (eng_delay+1)-th consecutive cycle of start.
  always @(posedge clk) eng_cnt <= eng_start ? eng_cnt + 1 : 0;
  assign eng_done    = eng_start && (eng_cnt == eng_delay);
  assign eng_mat_out = cmul(eng_mat_a, eng_mat_b);

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_resp(input int id);
    int k;
    k = 0;
    while (k < 40 && ((id == 0) ? r0_resp_valid : r1_resp_valid) !== 1'b1) begin
      cyc();
      k++;
    end
    chk("resp_wait_bound", k < 40, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    IDENT = '0;
    for (int k = 0; k < N; k++) IDENT[128*(k*N+k)] = 1'b1;
    A0 = {64'd7, 64'd1, 64'd0, 64'd2, 64'd3, 64'd0, 64'd5, 64'd4};
    A1 = {64'd0, 64'd9, 64'd2, 64'd0, 64'd1, 64'd1, 64'd0, 64'd6};
    B0 = {64'd1, 64'd8, 64'd3, 64'd3, 64'd0, 64'd2, 64'd4, 64'd0};
    B1 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
          64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001,
          64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h0F0F_0F0F_F0F0_F0F0, 64'h00FF_00FF_FF00_FF00};
    r0_mat_a = '0; r0_mat_b = '0; r1_mat_a = '0; r1_mat_b = '0;

    // Reset state
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_job_count", job_count, 16'd0);
    chk("rst_timeout_count", timeout_count, 8'd0);
    chk("rst_resp_mat", resp_mat, '0);
    chk("rst_resp_err", resp_err, 1'b0);
    cyc();
    reset = 1'b0;

    // Single job: identity * B1, done 5 cycles after start
    eng_delay = 5;
    r0_mat_a = IDENT; r0_mat_b = B1; r0_req_valid = 1'b1;
    #1;
    chk("t1_r0_req_ready", r0_req_ready, 1'b1);
    chk("t1_r1_req_ready", r1_req_ready, 1'b0);
    cyc();
    r0_req_valid = 1'b0;
    chk("t1_eng_start", eng_start, 1'b1);
    chk("t1_eng_valid", eng_valid, 1'b1);
    chk("t1_eng_mat_a", eng_mat_a, IDENT);
    chk("t1_eng_mat_b", eng_mat_b, B1);
    repeat (5) cyc();
    chk("t1_resp_valid_early", r0_resp_valid, 1'b0);
    cyc();
    chk("t1_resp_valid", r0_resp_valid, 1'b1);
    chk("t1_r1_resp_valid", r1_resp_valid, 1'b0);
    chk("t1_resp_mat", resp_mat, B1);
    chk("t1_resp_err", resp_err, 1'b0);
    chk("t1_job_count", job_count, 16'd1);
    chk("t1_eng_start_low", eng_start, 1'b0);
    r0_resp_ready = 1'b1;
    cyc();
    r0_resp_ready = 1'b0;
    chk("t1_idle_busy", busy, 1'b0);

    // Contention: both valid from reset, grants alternate 0,1,0,1
    do_reset();
    eng_delay = 2;
    r0_mat_a = A0; r0_mat_b = B0; r1_mat_a = A1; r1_mat_b = B1;
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("t2_r0_req_ready", r0_req_ready, (j % 2) == 0);
      chk("t2_r1_req_ready", r1_req_ready, (j % 2) == 1);
      cyc();
      exp_m = ((j % 2) == 0) ? cmul(A0, B0) : cmul(A1, B1);
      wait_resp(j % 2);
      chk("t2_resp_mat", resp_mat, exp_m);
      if ((j % 2) == 0) r0_resp_ready = 1'b1; else r1_resp_ready = 1'b1;
      cyc();
      r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;
    end
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    chk("t2_job_count", job_count, 16'd4);

    // Response backpressure on r1 while r0 waits
    r1_mat_a = A1; r1_mat_b = B0; r1_req_valid = 1'b1;
    #1;
    chk("t3_r1_req_ready", r1_req_ready, 1'b1);
    cyc();
    r1_req_valid = 1'b0;
    r0_mat_a = A0; r0_mat_b = B1; r0_req_valid = 1'b1;
    wait_resp(1);
    for (int j = 0; j < 10; j++) begin
      chk("t3_hold_resp_valid", r1_resp_valid, 1'b1);
      chk("t3_hold_resp_mat", resp_mat, cmul(A1, B0));
      chk("t3_hold_r0_req_ready", r0_req_ready, 1'b0);
      cyc();
    end
    r1_resp_ready = 1'b1;
    cyc();
    r1_resp_ready = 1'b0;
    #1;
    chk("t3_idle_busy", busy, 1'b0);
    chk("t3_resp_valid_drop", r1_resp_valid, 1'b0);
    chk("t3_r0_req_ready", r0_req_ready, 1'b1);
    cyc();
    r0_req_valid = 1'b0;
    wait_resp(0);
    chk("t3_r0_resp_mat", resp_mat, cmul(A0, B1));
    r0_resp_ready = 1'b1;
    cyc();
    r0_resp_ready = 1'b0;
    chk("t3_job_count", job_count, 16'd6);

    // Done on the final watchdog cycle
    eng_delay = TO - 1;
    r0_mat_a = A1; r0_mat_b = A0; r0_req_valid = 1'b1;
    cyc();
    r0_req_valid = 1'b0;
    repeat (TO - 1) cyc();
    chk("t5_eng_start_last", eng_start, 1'b1);
    chk("t5_resp_valid_early", r0_resp_valid, 1'b0);
    cyc();
    chk("t5_resp_valid", r0_resp_valid, 1'b1);
    chk("t5_resp_err", resp_err, 1'b0);
    chk("t5_resp_mat", resp_mat, cmul(A1, A0));
    chk("t5_job_count", job_count, 16'd7);
    chk("t5_timeout_count", timeout_count, 8'd0);
    r0_resp_ready = 1'b1;
    cyc();
    r0_resp_ready = 1'b0;

    // Timeout: engine never completes
    eng_delay = 1000;
    r1_mat_a = A0; r1_mat_b = B0; r1_req_valid = 1'b1;
    cyc();
    r1_req_valid = 1'b0;
    repeat (TO - 1) cyc();
    chk("t4_eng_start_last", eng_start, 1'b1);
    cyc();
    chk("t4_eng_start_low", eng_start, 1'b0);
    chk("t4_resp_valid", r1_resp_valid, 1'b1);
    chk("t4_resp_err", resp_err, 1'b1);
    chk("t4_resp_mat_zero", resp_mat, '0);
    chk("t4_timeout_count", timeout_count, 8'd1);
    chk("t4_job_count", job_count, 16'd7);
    r1_resp_ready = 1'b1;
    cyc();
    r1_resp_ready = 1'b0;
    for (int j = 1; j < 260; j++) begin
      r0_req_valid = 1'b1;
      cyc();
      r0_req_valid = 1'b0;
      wait_resp(0);
      r0_resp_ready = 1'b1;
      cyc();
      r0_resp_ready = 1'b0;
      if (j == 254) chk("t4_timeout_255", timeout_count, 8'd255);
    end
    chk("t4_timeout_sat", timeout_count, 8'd255);

    // Reset three cycles into a job
    eng_delay = 5;
    r1_mat_a = A0; r1_mat_b = B0; r1_req_valid = 1'b1;
    cyc();
    r1_req_valid = 1'b0;
    cyc();
    cyc();
    chk("t6_eng_start_run", eng_start, 1'b1);
    reset = 1'b1;
    cyc();
    chk("t6_eng_start", eng_start, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_resp_valid", r1_resp_valid, 1'b0);
    chk("t6_job_count", job_count, 16'd0);
    chk("t6_timeout_count", timeout_count, 8'd0);
    reset = 1'b0;
    repeat (6) begin
      cyc();
      chk("t6_no_resp", r1_resp_valid, 1'b0);
    end
    r0_mat_a = IDENT; r0_mat_b = B1; r0_req_valid = 1'b1;
    #1;
    chk("t6_r0_req_ready", r0_req_ready, 1'b1);
    cyc();
    r0_req_valid = 1'b0;
    wait_resp(0);
    chk("t6_resp_mat", resp_mat, B1);
    chk("t6_job_count_after", job_count, 16'd1);
    r0_resp_ready = 1'b1;
    cyc();
    r0_resp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
